// File: rtl/bip_run_control.sv
// ---------------------------------------------------------------------------
// bip_run_control
//
// Run/step/halt controller for the BIP CPU. A small host command channel
// (NOP/RUN/STEP/STOP) moves the controller between IDLE, RUN, STEP and HALT.
// o_valid is the CPU advance enable: the CPU moves forward only in cycles
// where it is high. Execution stops on its own when the HALT opcode reaches
// the CPU and, optionally, when the PC matches a breakpoint address.
//
// Build option:
//   BIP_RUN_CONTROL_BREAKPOINT_EN  when defined, the PC breakpoint logic and
//                                  the o_bp_hit pulse are compiled in. When
//                                  undefined, i_bp_en/i_bp_addr are ignored
//                                  and o_bp_hit is tied to 0.
//
// Ports:
//   i_clock        clock, all state changes on its rising edge
//   i_reset        asynchronous, active-low reset
//   i_cmd          command: 00 NOP, 01 RUN, 10 STEP, 11 STOP
//   i_cmd_valid    command present
//   o_cmd_ready    command can be accepted (low only in STEP)
//   i_pc           current CPU PC
//   i_instruction  instruction currently presented to the CPU
//   i_bp_en        breakpoint enable
//   i_bp_addr      breakpoint PC
//   o_valid        CPU advance enable (combinational)
//   o_state        FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   o_done         one-cycle pulse after entering HALT
//   o_bp_hit       one-cycle pulse after a breakpoint stop
//   o_cycle_count  saturating count of cycles with o_valid=1
// ---------------------------------------------------------------------------
module bip_run_control #(
    parameter int                   NB_DATA            = 16,
    parameter int                   NB_OPCODE          = 5,
    parameter int                   LOG2_N_INSMEM_ADDR = 11,
    parameter int                   NB_CYCLE_CNT       = 32,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE        = {NB_OPCODE{1'b0}}
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [1:0]                    i_cmd,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0]            i_instruction,
    input  logic                          i_bp_en,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_bp_addr,
    output logic                          o_valid,
    output logic [1:0]                    o_state,
    output logic                          o_done,
    output logic                          o_bp_hit,
    output logic [NB_CYCLE_CNT-1:0]       o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam logic [NB_CYCLE_CNT-1:0] CNT_ONE = {{(NB_CYCLE_CNT-1){1'b0}}, 1'b1};

    state_t                  state;
    logic                    first_cycle;
    logic                    done_q;
    logic [NB_CYCLE_CNT-1:0] cycle_count;

    logic [NB_OPCODE-1:0]    opcode;
    logic                    halt_hit;
    logic                    bp_hit;
    logic                    cmd_accept;
    logic                    advance;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [NB_CYCLE_CNT-1:0] sat_inc(input logic [NB_CYCLE_CNT-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    // Opcode decode: only the top NB_OPCODE bits matter to this block.
    assign opcode   = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign halt_hit = (opcode == HALT_OPCODE);

    logic unused_instr;
    assign unused_instr = ^i_instruction[NB_DATA-NB_OPCODE-1:0];

`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
    logic bp_pulse;

    // first_cycle masks the match on the cycle RUN is entered, so resuming
    // from the breakpoint PC executes that instruction instead of stopping
    // again immediately.
    assign bp_hit   = (state == ST_RUN) && i_bp_en && (i_pc == i_bp_addr) && !first_cycle;
    assign o_bp_hit = bp_pulse;
`else
    assign bp_hit   = 1'b0;
    assign o_bp_hit = 1'b0;

    logic unused_bp;
    assign unused_bp = ^{i_bp_en, i_bp_addr, i_pc, first_cycle};
`endif

    assign cmd_accept = i_cmd_valid && o_cmd_ready;
    assign o_cmd_ready = (state != ST_STEP);

    // The halt instruction itself is never executed; a breakpoint stops
    // before the instruction at the breakpoint PC.
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_RUN:  advance = !halt_hit && !bp_hit;
            ST_STEP: advance = !halt_hit;
            default: advance = 1'b0;
        endcase
    end

    assign o_valid       = advance;
    assign o_state       = state;
    assign o_done        = done_q;
    assign o_cycle_count = cycle_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            first_cycle <= 1'b0;
            done_q      <= 1'b0;
            cycle_count <= '0;
`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
            bp_pulse    <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            first_cycle <= 1'b0;
`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
            bp_pulse    <= 1'b0;
`endif
            if (advance) begin
                cycle_count <= sat_inc(cycle_count);
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_accept && (i_cmd == CMD_RUN)) begin
                        state       <= ST_RUN;
                        first_cycle <= 1'b1;
                    end else if (cmd_accept && (i_cmd == CMD_STEP)) begin
                        state <= ST_STEP;
                    end
                end

                // Priority: halt, then breakpoint, then host STOP. A STOP
                // that loses to halt/breakpoint is still consumed.
                ST_RUN: begin
                    if (halt_hit) begin
                        state  <= ST_HALT;
                        done_q <= 1'b1;
                    end else if (bp_hit) begin
                        state <= ST_IDLE;
`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
                        bp_pulse <= 1'b1;
`endif
                    end else if (cmd_accept && (i_cmd == CMD_STOP)) begin
                        state <= ST_IDLE;
                    end
                end

                ST_STEP: begin
                    if (halt_hit) begin
                        state  <= ST_HALT;
                        done_q <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                // Only STOP leaves HALT; it also clears the cycle counter so
                // the next program run starts counting from zero.
                ST_HALT: begin
                    if (cmd_accept && (i_cmd == CMD_STOP)) begin
                        state       <= ST_IDLE;
                        cycle_count <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_run_control.sv
`timescale 1ns/1ps
module tb_bip_run_control;

    localparam int DW      = 16;
    localparam int OW      = 5;
    localparam int AW      = 11;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
    localparam bit BP_BUILD = 1'b1;
`else
    localparam bit BP_BUILD = 1'b0;
`endif

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic [1:0]    cmd       = 2'b00;
    logic          cmd_valid = 1'b0;
    logic          bp_en     = 1'b0;
    logic [AW-1:0] bp_addr   = '0;
    logic [AW-1:0] halt_at   = '1;
    logic          pc_clr    = 1'b1;
    logic [AW-1:0] cpu_pc    = '0;
    logic [DW-1:0] instr;

    logic          dut_ready;
    logic          dut_valid;
    logic [1:0]    dut_state;
    logic          dut_done;
    logic          dut_bp;
    logic [CW-1:0] dut_count;

    int n_chk  = 0;
    int n_fail = 0;

    bip_run_control #(
        .NB_DATA            (DW),
        .NB_OPCODE          (OW),
        .LOG2_N_INSMEM_ADDR (AW),
        .NB_CYCLE_CNT       (CW),
        .HALT_OPCODE        (5'b00000)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_cmd         (cmd),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (dut_ready),
        .i_pc          (cpu_pc),
        .i_instruction (instr),
        .i_bp_en       (bp_en),
        .i_bp_addr     (bp_addr),
        .o_valid       (dut_valid),
        .o_state       (dut_state),
        .o_done        (dut_done),
        .o_bp_hit      (dut_bp),
        .o_cycle_count (dut_count)
    );

    always #5 clk = ~clk;

    // Toy CPU: PC advances on every edge where the controller enables it.
    // Program memory holds opcode 00001 everywhere except the halt slot.
    always @(posedge clk) begin
        if (pc_clr) cpu_pc <= '0;
        else if (dut_valid) cpu_pc <= cpu_pc + 1'b1;
    end
    assign instr = (cpu_pc == halt_at) ? 16'h0000 : {5'b00001, cpu_pc};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the controller mode by the rules, checks every
    // output at the falling edge, then advances assuming the inputs hold
    // through the next rising edge.
    int m_mode  = 0;  // 0 idle, 1 running, 2 single step, 3 halted
    bit m_fresh = 1'b0;
    bit m_done  = 1'b0;
    bit m_bp    = 1'b0;
    int m_cnt   = 0;

    always @(negedge clk) begin : model
        bit halt, bp, rdy, acc, vld;
        if (!rst_n) begin
            m_mode = 0; m_fresh = 1'b0; m_done = 1'b0; m_bp = 1'b0; m_cnt = 0;
        end
        halt = (instr[DW-1 -: OW] == 5'b00000);
        bp   = BP_BUILD && (m_mode == 1) && bp_en && (cpu_pc == bp_addr) && !m_fresh;
        rdy  = (m_mode != 2);
        acc  = cmd_valid && rdy;
        vld  = ((m_mode == 1) && !halt && !bp) || ((m_mode == 2) && !halt);

        chk("m_state", dut_state, m_mode);
        chk("m_valid", dut_valid, vld);
        chk("m_ready", dut_ready, rdy);
        chk("m_done",  dut_done,  m_done);
        chk("m_bp",    dut_bp,    m_bp);
        chk("m_count", dut_count, m_cnt);

        if (rst_n) begin
            m_done  = 1'b0;
            m_bp    = 1'b0;
            m_fresh = 1'b0;
            if (vld && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            case (m_mode)
                0: begin
                    if (acc && cmd == C_RUN) begin m_mode = 1; m_fresh = 1'b1; end
                    else if (acc && cmd == C_STEP) m_mode = 2;
                end
                1: begin
                    if (halt) begin m_mode = 3; m_done = 1'b1; end
                    else if (bp) begin m_mode = 0; m_bp = 1'b1; end
                    else if (acc && cmd == C_STOP) m_mode = 0;
                end
                2: begin
                    if (halt) begin m_mode = 3; m_done = 1'b1; end
                    else m_mode = 0;
                end
                default: begin
                    if (acc && cmd == C_STOP) begin m_mode = 0; m_cnt = 0; end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd = C_NOP;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_clr = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        pc_clr = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pc_clr = 1'b0;

        // Idle after reset
        repeat (10) tick();
        chk("idle_state", dut_state, 2'b00);
        chk("idle_valid", dut_valid, 1'b0);
        chk("idle_count", dut_count, 0);

        // Single step with a non-halt opcode
        send(C_STEP);
        chk("step_state", dut_state, 2'b10);
        chk("step_valid", dut_valid, 1'b1);
        chk("step_ready", dut_ready, 1'b0);
        tick();
        chk("step_end_state", dut_state, 2'b00);
        chk("step_end_count", dut_count, 1);
        chk("step_end_ready", dut_ready, 1'b1);
        chk("step_end_pc",    cpu_pc,    1);

        // Run into a halt opcode at PC 7
        do_reset();
        halt_at = 11'd7;
        send(C_RUN);
        n = 0;
        for (int i = 0; i < 20 && dut_state == 2'b01; i++) begin
            if (dut_valid) n++;
            tick();
        end
        chk("halt_valid_cycles", n, 7);
        chk("halt_state", dut_state, 2'b11);
        chk("halt_done",  dut_done,  1'b1);
        chk("halt_count", dut_count, 7);
        send(C_RUN);
        chk("halt_run_ignored", dut_state, 2'b11);
        chk("halt_done_once",   dut_done,  1'b0);
        send(C_STEP);
        chk("halt_step_ignored", dut_state, 2'b11);
        send(C_STOP);
        chk("halt_stop_state", dut_state, 2'b00);
        chk("halt_stop_count", dut_count, 0);

        // Breakpoint at PC 5
        do_reset();
        halt_at = '1;
        bp_en = 1'b1;
        bp_addr = 11'h005;
        send(C_RUN);
        n = 0;
        for (int i = 0; i < 20 && dut_state == 2'b01; i++) begin
            if (dut_valid) n++;
            tick();
        end
`ifdef BIP_RUN_CONTROL_BREAKPOINT_EN
        chk("bp_valid_cycles", n, 5);
        chk("bp_state",  dut_state, 2'b00);
        chk("bp_pulse",  dut_bp,    1'b1);
        chk("bp_pc",     cpu_pc,    5);
        send(C_RUN);
        chk("bp_resume_valid", dut_valid, 1'b1);
        chk("bp_pulse_once",   dut_bp,    1'b0);
        tick();
        tick();
        tick();
        chk("bp_resume_pc",    cpu_pc,    8);
        chk("bp_resume_state", dut_state, 2'b01);
`else
        chk("nobp_valid_cycles", n, 20);
        chk("nobp_pc",    cpu_pc,    20);
        chk("nobp_pulse", dut_bp,    1'b0);
`endif
        send(C_STOP);
        chk("bp_stop_state", dut_state, 2'b00);
        bp_en = 1'b0;

        // Halt and STOP in the same cycle: halt wins
        do_reset();
        halt_at = 11'd2;
        send(C_RUN);
        for (int i = 0; i < 10 && cpu_pc != 11'd2; i++) tick();
        send(C_STOP);
        chk("race_state", dut_state, 2'b11);
        chk("race_done",  dut_done,  1'b1);
        chk("race_count", dut_count, 2);
        send(C_STOP);
        chk("race_clear", dut_count, 0);

        // Reset in the middle of a run
        do_reset();
        halt_at = '1;
        send(C_RUN);
        tick();
        tick();
        tick();
        chk("mid_count", dut_count, 3);
        rst_n = 1'b0;
        pc_clr = 1'b1;
        #1;
        chk("mid_rst_valid", dut_valid, 1'b0);
        chk("mid_rst_count", dut_count, 0);
        chk("mid_rst_state", dut_state, 2'b00);
        tick();
        rst_n = 1'b1;
        pc_clr = 1'b0;
        tick();
        chk("mid_rst_done", dut_done, 1'b0);

        // Counter saturation, and STOP in RUN keeps the count
        send(C_RUN);
        repeat (20) tick();
        chk("sat_count", dut_count, CNT_MAX);
        chk("sat_state", dut_state, 2'b01);
        send(C_STOP);
        chk("sat_stop_state", dut_state, 2'b00);
        chk("sat_stop_count", dut_count, CNT_MAX);
        tick();
        chk("sat_hold", dut_count, CNT_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_run_control.md
BIP_RUN_CONTROL -- requirements
Module: bip_run_control

Interface
REQ-001 Parameter NB_DATA, default 16, SHALL be the instruction width.
REQ-002 Parameter NB_OPCODE, default 5, SHALL be the opcode field width, taken from instruction bits [NB_DATA-1 -: NB_OPCODE].
REQ-003 Parameter LOG2_N_INSMEM_ADDR, default 11, SHALL be the PC width.
REQ-004 Parameter NB_CYCLE_CNT, default 32, SHALL be the cycle counter width.
REQ-005 Parameter HALT_OPCODE, default 5'b00000, SHALL be the opcode that halts execution.
REQ-006 Ports SHALL be, in this order:
  i_clock  in  1  single clock; all state changes on its rising edge.
  i_reset  in  1  asynchronous, active-low reset.
  i_cmd  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
  i_cmd_valid  in  1  command present.
  o_cmd_ready  out  1  command can be accepted.
  i_pc  in  LOG2_N_INSMEM_ADDR  current CPU PC.
  i_instruction  in  NB_DATA  instruction currently presented to the CPU.
  i_bp_en  in  1  breakpoint enable.
  i_bp_addr  in  LOG2_N_INSMEM_ADDR  breakpoint PC.
  o_valid  out  1  CPU advance enable, driven to the CPU valid input.
  o_state  out  2  FSM state code.
  o_done  out  1  one-cycle pulse on entry to HALT.
  o_bp_hit  out  1  one-cycle pulse on a breakpoint stop.
  o_cycle_count  out  NB_CYCLE_CNT  number of cycles with o_valid=1.

Function
REQ-007 The FSM SHALL have the states IDLE=00, RUN=01, STEP=10 and HALT=11; o_state SHALL equal the current state register.
REQ-008 A command SHALL be accepted only in a cycle where i_cmd_valid=1 and o_cmd_ready=1.
REQ-009 o_cmd_ready SHALL be 1 in IDLE, RUN and HALT, and 0 in STEP.
REQ-010 halt_hit SHALL be asserted when i_instruction opcode equals HALT_OPCODE.
REQ-011 o_valid SHALL be combinational: 1 in RUN when neither halt_hit nor bp_hit is asserted; 1 in STEP when halt_hit is not asserted; 0 otherwise.
REQ-012 IDLE transitions SHALL be: accepted RUN -> RUN; accepted STEP -> STEP; STOP or NOP -> remain in IDLE.
REQ-013 RUN transitions SHALL be evaluated in priority order:
  - halt_hit -> HALT.
  - bp_hit -> IDLE.
  - accepted STOP -> IDLE, with o_valid still 1 in the accepting cycle.
  - RUN, STEP and NOP -> remain in RUN.
REQ-014 STEP SHALL last exactly one cycle; it SHALL go to HALT if halt_hit is asserted and to IDLE otherwise.
REQ-015 HALT transitions SHALL be: accepted STOP -> IDLE and clears o_cycle_count; accepted RUN, STEP or NOP -> no effect.
REQ-016 In RUN, the simultaneous occurrence of halt_hit, bp_hit and a STOP command SHALL resolve by priority: HALT, then breakpoint, then STOP; the STOP SHALL still count as accepted.
REQ-017 o_done SHALL be registered and equal 1 for exactly the one cycle after a transition into HALT.
REQ-018 o_cycle_count SHALL increment by 1 on each clock edge where o_valid=1.
REQ-019 o_cycle_count SHALL saturate at its all-ones value and SHALL NOT wrap around.
REQ-020 o_cycle_count SHALL be cleared only by reset or by a STOP accepted in HALT.

Reset
REQ-021 While i_reset=0, the block SHALL immediately force:
  - state = IDLE.
  - o_valid = 0.
  - o_done = 0.
  - o_bp_hit = 0.
  - o_cycle_count = 0.
  - the first-cycle flag = 0.
REQ-022 A reset asserted mid-RUN or mid-STEP SHALL abort execution without producing a done or breakpoint pulse.

Configuration
REQ-023 Macro BIP_RUN_CONTROL_BREAKPOINT_EN SHALL compile the breakpoint feature in or out.
REQ-024 With BIP_RUN_CONTROL_BREAKPOINT_EN defined, bp_hit SHALL equal: state==RUN AND i_bp_en AND i_pc==i_bp_addr AND NOT first-cycle.
REQ-025 The first-cycle flag SHALL be set on the edge that enters RUN and cleared after one cycle, so that resuming execution from the breakpoint PC passes that PC.
REQ-026 With BIP_RUN_CONTROL_BREAKPOINT_EN defined, o_bp_hit SHALL be a registered one-cycle pulse following the bp_hit cycle.
REQ-027 Without BIP_RUN_CONTROL_BREAKPOINT_EN, bp_hit SHALL be constant 0 and o_bp_hit SHALL be tied to 0; i_bp_en and i_bp_addr SHALL remain as ports but be ignored.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Reset, then no commands for 10 cycles -> o_state=00, o_valid=0, o_cycle_count=0 throughout.
  - STEP accepted with a non-halt opcode -> o_valid=1 for exactly 1 cycle, then o_state=00, o_cycle_count=1, o_cmd_ready=0 only during the step cycle.
  - RUN, with the halt opcode presented after 7 non-halt cycles -> o_valid=1 for 7 cycles and 0 in the halt cycle, o_state=11, o_done pulses once, o_cycle_count=7; a STOP then gives o_state=00 and o_cycle_count=0.
  - Macro defined, i_bp_en=1, i_bp_addr=0x005, PC incrementing from 0 -> stop in the cycle where PC=5 with o_valid=0 and o_bp_hit pulsing; a second RUN advances past PC 5.
  - RUN with halt_hit and STOP asserted in the same cycle -> o_state=11 and o_done=1.
  - Reset asserted mid-RUN with o_cycle_count=3 -> o_valid drops immediately and the counter reads 0.
